// File: rtl/traffic_pkg.sv
// Shared phase encoding, default durations and small helpers for the
// multi-phase traffic controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_GREEN   = 2'd0,
    PH_YELLOW  = 2'd1,
    PH_ALL_RED = 2'd2,
    PH_FLASH   = 2'd3
  } phase_e;

  localparam int DEF_N_DIR      = 4;
  localparam int DEF_GREEN_MIN  = 20;
  localparam int DEF_GREEN_MAX  = 100;
  localparam int DEF_YELLOW_T   = 20;
  localparam int DEF_ALLRED_T   = 5;
  localparam int DEF_FLASH_HALF = 10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin pick of the next approach to receive green: first pending
// approach after active_dir (wrapping), else simply active_dir+1.
module rr_next_sel #(
  parameter int N_DIR = 4,
  localparam int DW = $clog2(N_DIR)
) (
  input  logic [N_DIR-1:0] pending,
  input  logic [DW-1:0]    active_dir,
  output logic [DW-1:0]    next_dir
);

  logic [DW-1:0] idx_s;

  // Scan farthest candidate first so the nearest pending one is assigned last.
  always_comb begin
    next_dir = DW'((int'(active_dir) + 1) % N_DIR);
    idx_s    = active_dir;
    for (int k = N_DIR; k >= 1; k--) begin
      idx_s    = DW'((int'(active_dir) + k) % N_DIR);
      next_dir = pending[idx_s] ? idx_s : next_dir;
    end
  end

endmodule

// File: rtl/multi_phase_traffic_ctrl.sv
// Multi-approach signal controller: GREEN -> YELLOW -> ALL_RED rotation with
// request-driven early exit, round-robin service and a night flashing mode.
module multi_phase_traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int N_DIR      = DEF_N_DIR,
  parameter int GREEN_MIN  = DEF_GREEN_MIN,
  parameter int GREEN_MAX  = DEF_GREEN_MAX,
  parameter int YELLOW_T   = DEF_YELLOW_T,
  parameter int ALLRED_T   = DEF_ALLRED_T,
  parameter int FLASH_HALF = DEF_FLASH_HALF,
  localparam int DW = $clog2(N_DIR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_DIR-1:0] req,
  input  logic             flash_en,
  output logic [N_DIR-1:0] red,
  output logic [N_DIR-1:0] yellow,
  output logic [N_DIR-1:0] green,
  output logic [DW-1:0]    active_dir,
  output logic [N_DIR-1:0] pending
);

  localparam int TW = $clog2(max3(GREEN_MAX, YELLOW_T, ALLRED_T) + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);

  phase_e           state_r, state_nxt_s;
  logic [TW-1:0]    timer_r;
  logic [FW-1:0]    flash_cnt_r;
  logic             flash_lit_r;
  logic [DW-1:0]    active_dir_r;
  logic [DW-1:0]    next_dir_s;
  logic [N_DIR-1:0] pending_r;
  logic [N_DIR-1:0] act_oh_s, set_s, clr_s;
  logic             other_pend_s, green_done_s, yellow_done_s, allred_done_s;
  logic             enter_green_s;

  assign act_oh_s      = {{(N_DIR-1){1'b0}}, 1'b1} << active_dir_r;
  assign other_pend_s  = |(pending_r & ~act_oh_s);
  assign green_done_s  = (timer_r == TW'(GREEN_MAX - 1)) ||
                         ((timer_r >= TW'(GREEN_MIN - 1)) && (other_pend_s || flash_en));
  assign yellow_done_s = (timer_r == TW'(YELLOW_T - 1));
  assign allred_done_s = (timer_r == TW'(ALLRED_T - 1));
  assign enter_green_s = (state_r == PH_ALL_RED) && allred_done_s && !flash_en;

  // The owner of a running green cannot queue itself; entering green clears its bit.
  assign set_s = req & ~((state_r == PH_GREEN) ? act_oh_s : {N_DIR{1'b0}});
  assign clr_s = enter_green_s ? ({{(N_DIR-1){1'b0}}, 1'b1} << next_dir_s) : {N_DIR{1'b0}};

  rr_next_sel #(.N_DIR(N_DIR)) u_rr_next_sel (
    .pending    (pending_r),
    .active_dir (active_dir_r),
    .next_dir   (next_dir_s)
  );

  // Phase state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= PH_GREEN;
    else       state_r <= state_nxt_s;
  end

  // Phase transition rules; flash_en is deliberately not consulted in YELLOW.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      PH_GREEN:   state_nxt_s = green_done_s  ? PH_YELLOW : PH_GREEN;
      PH_YELLOW:  state_nxt_s = yellow_done_s ? PH_ALL_RED : PH_YELLOW;
      PH_ALL_RED: begin
        if (allred_done_s) state_nxt_s = flash_en ? PH_FLASH : PH_GREEN;
        else               state_nxt_s = PH_ALL_RED;
      end
      PH_FLASH:   state_nxt_s = flash_en ? PH_FLASH : PH_ALL_RED;
      default:    state_nxt_s = PH_GREEN;
    endcase
  end

  // Phase timer (saturating), flash blink phase, owner and request latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_r      <= {TW{1'b0}};
      flash_cnt_r  <= {FW{1'b0}};
      flash_lit_r  <= 1'b1;
      active_dir_r <= {DW{1'b0}};
      pending_r    <= {N_DIR{1'b0}};
    end else begin
      if (state_nxt_s != state_r)    timer_r <= {TW{1'b0}};
      else if (timer_r != {TW{1'b1}}) timer_r <= timer_r + TW'(1);
      else                            timer_r <= timer_r;

      if ((state_r == PH_FLASH) && (state_nxt_s == PH_FLASH)) begin
        if (flash_cnt_r == FW'(FLASH_HALF - 1)) begin
          flash_cnt_r <= {FW{1'b0}};
          flash_lit_r <= ~flash_lit_r;
        end else begin
          flash_cnt_r <= flash_cnt_r + FW'(1);
          flash_lit_r <= flash_lit_r;
        end
      end else begin
        flash_cnt_r <= {FW{1'b0}};
        flash_lit_r <= 1'b1;
      end

      active_dir_r <= enter_green_s ? next_dir_s : active_dir_r;
      pending_r    <= (pending_r | set_s) & ~clr_s;
    end
  end

  // Lamp decode from registered state only.
  always_comb begin
    red    = {N_DIR{1'b0}};
    yellow = {N_DIR{1'b0}};
    green  = {N_DIR{1'b0}};
    case (state_r)
      PH_GREEN: begin
        red   = ~act_oh_s;
        green = act_oh_s;
      end
      PH_YELLOW: begin
        red    = ~act_oh_s;
        yellow = act_oh_s;
      end
      PH_ALL_RED: red    = {N_DIR{1'b1}};
      PH_FLASH:   yellow = {N_DIR{flash_lit_r}};
      default:    red    = {N_DIR{1'b1}};
    endcase
  end

  assign active_dir = active_dir_r;
  assign pending    = pending_r;

endmodule

// File: tb/tb_multi_phase_traffic_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// against a cycle-level behavioural model of the signal plan.
module tb_multi_phase_traffic_ctrl;

  localparam int N    = 4;
  localparam int GMIN = 4;
  localparam int GMAX = 10;
  localparam int YT   = 3;
  localparam int ART  = 2;
  localparam int FH   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       flash_en = 1'b0;
  logic [3:0] red, yellow, green, pending;
  logic [1:0] active_dir;

  int n_checks = 0;
  int n_fail   = 0;

  // model: phase 0=green 1=yellow 2=all-red 3=flash, cycles elapsed in phase
  int         m_ph, m_el, m_dir;
  logic [3:0] m_pend;

  always #5 clk = ~clk;

  multi_phase_traffic_ctrl #(
    .N_DIR(N), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
    .YELLOW_T(YT), .ALLRED_T(ART), .FLASH_HALF(FH)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .flash_en(flash_en),
    .red(red), .yellow(yellow), .green(green),
    .active_dir(active_dir), .pending(pending)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] p, input int d);
    for (int k = 1; k <= N; k++)
      if (p[(d + k) % N]) return (d + k) % N;
    return (d + 1) % N;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_dir = 0; m_pend = 4'b0000;
  endtask

  task automatic compare_model(input string sc);
    int er, ey, eg;
    er = 0; ey = 0; eg = 0;
    for (int i = 0; i < N; i++) begin
      if (m_ph == 0) begin
        if (i == m_dir) eg |= (1 << i); else er |= (1 << i);
      end else if (m_ph == 1) begin
        if (i == m_dir) ey |= (1 << i); else er |= (1 << i);
      end else if (m_ph == 2) begin
        er |= (1 << i);
      end else if (((m_el / FH) % 2) == 0) begin
        ey |= (1 << i);
      end
    end
    check({sc, "_red"}, red, er);
    check({sc, "_yellow"}, yellow, ey);
    check({sc, "_green"}, green, eg);
    check({sc, "_dir"}, active_dir, m_dir);
    check({sc, "_pending"}, pending, m_pend);
  endtask

  task automatic model_step(input logic [3:0] r, input logic fl, input logic rst);
    int nph, nd;
    bit other, eg;
    if (rst) begin
      model_reset();
      return;
    end
    nph = m_ph; nd = m_dir; eg = 0;
    other = (m_pend & ~(4'b0001 << m_dir)) != 4'b0000;
    case (m_ph)
      0: if (m_el == GMAX - 1 || (m_el >= GMIN - 1 && (other || fl))) nph = 1;
      1: if (m_el == YT - 1) nph = 2;
      2: if (m_el == ART - 1) begin
           if (fl) nph = 3;
           else begin nph = 0; eg = 1; nd = pick(m_pend, m_dir); end
         end
      default: if (!fl) nph = 2;
    endcase
    for (int i = 0; i < N; i++) begin
      if (r[i] && !(m_ph == 0 && i == m_dir)) m_pend[i] = 1'b1;
      if (eg && i == nd) m_pend[i] = 1'b0;
    end
    m_el  = (nph != m_ph) ? 0 : m_el + 1;
    m_ph  = nph;
    m_dir = nd;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b0000; flash_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Directed spot checks against timings worked out by hand.
  task automatic spot(input int mode, input int c);
    case (mode)
      0: begin
        if (c == 9)  check("s0_green9", green, 4'b0001);
        if (c == 10) check("s0_yellow10", yellow, 4'b0001);
        if (c == 13) check("s0_allred13", red, 4'b1111);
        if (c == 15) check("s0_green15", green, 4'b0010);
        if (c == 45) check("s0_dir45", active_dir, 3);
        if (c == 60) check("s0_wrap60", active_dir, 0);
      end
      1: begin
        if (c == 2) check("s1_pend2", pending, 4'b0100);
        if (c == 4) check("s1_yellow4", yellow, 4'b0001);
        if (c == 9) check("s1_green9", green, 4'b0100);
        if (c == 9) check("s1_pend9", pending, 4'b0000);
      end
      2: begin
        if (c == 9)  check("s2_dir9", active_dir, 1);
        if (c == 18) check("s2_dir18", active_dir, 3);
      end
      3: begin
        if (c == 9)  check("s3_pend9", pending, 4'b0000);
        if (c == 9)  check("s3_green9", green, 4'b0001);
        if (c == 10) check("s3_yellow10", yellow, 4'b0001);
      end
      4: begin
        if (c == 4)  check("s4_yellow4", yellow, 4'b0001);
        if (c == 7)  check("s4_allred7", red, 4'b1111);
        if (c == 9)  check("s4_flash9", yellow, 4'b1111);
        if (c == 10) check("s4_flash10", yellow, 4'b1111);
        if (c == 11) check("s4_dark11", yellow, 4'b0000);
        if (c == 11) check("s4_nored11", red, 4'b0000);
        if (c == 13) check("s4_allred13", red, 4'b1111);
        if (c == 15) check("s4_green15", green, 4'b0010);
      end
      default: ;
    endcase
  endtask

  task automatic run(input int mode, input int ncyc);
    string sc;
    sc = $sformatf("m%0d", mode);
    for (int c = 0; c < ncyc; c++) begin
      compare_model(sc);
      spot(mode, c);
      case (mode)
        1: req = (c == 1) ? 4'b0100 : 4'b0000;
        2: req = (c <= 3) ? 4'b1010 : 4'b0000;
        3: req = (c <= 9) ? 4'b0001 : 4'b0000;
        4: flash_en = (c >= 2 && c <= 11);
        5: begin
          for (int i = 0; i < N; i++) req[i] = ($urandom_range(0, 7) == 0);
          if ($urandom_range(0, 149) == 0) flash_en = ~flash_en;
          reset = ($urandom_range(0, 399) == 0);
        end
        default: begin req = 4'b0000; flash_en = 1'b0; end
      endcase
      model_step(req, flash_en, reset);
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("reset_green", green, 4'b0001);
    check("reset_red", red, 4'b1110);
    check("reset_yellow", yellow, 4'b0000);
    check("reset_pending", pending, 4'b0000);
    run(0, 62);
    do_reset(); run(1, 12);
    do_reset(); run(2, 20);
    do_reset(); run(3, 12);
    do_reset(); run(4, 18);

    // reset landing in the middle of a yellow with a request outstanding
    do_reset(); run(1, 5);
    check("ry_yellow_before", yellow, 4'b0001);
    check("ry_pend_before", pending, 4'b0100);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("ry_green", green, 4'b0001);
    check("ry_yellow", yellow, 4'b0000);
    check("ry_pending", pending, 4'b0000);

    do_reset(); run(5, 4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
